// File: rtl/instruc_fetch_pkg.sv
// Shared constants and fetch-state encoding for the RV32I fetch stage.
package instruc_fetch_pkg;
   localparam int          XLEN       = 32;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [31:0] HALT_INSTR = 32'h0000_0073;
   localparam int          HALT_DRAIN = 2;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/instruc_fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, flush to a bubble, or hold.
module instruc_fetch_if_id_reg #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            flush,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [31:0]     instruc,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [31:0]     id_instruc,
   output logic            id_valid
);

   // A flush only replaces the instruction; the PC fields keep their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_pc       <= '0;
         id_pc_plus4 <= '0;
         id_instruc  <= NOP_INSTR;
         id_valid    <= 1'b0;
      end else if (flush) begin
         id_instruc  <= NOP_INSTR;
         id_valid    <= 1'b0;
      end else if (load) begin
         id_pc       <= pc;
         id_pc_plus4 <= pc_plus4;
         id_instruc  <= instruc;
         id_valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/instruc_fetch.sv
// Fetch stage: PC register, next-PC selection, halt-drain FSM and the IF/ID register.
module instruc_fetch #(
   parameter int          XLEN       = instruc_fetch_pkg::XLEN,
   parameter logic [31:0] RESET_PC   = instruc_fetch_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR  = instruc_fetch_pkg::NOP_INSTR,
   parameter logic [31:0] HALT_INSTR = instruc_fetch_pkg::HALT_INSTR,
   parameter int          HALT_DRAIN = instruc_fetch_pkg::HALT_DRAIN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [31:0]     id_instruc,
   output logic            id_valid,
   output logic            halted
);
   import instruc_fetch_pkg::*;

   localparam int CNT_W = (HALT_DRAIN > 2) ? $clog2(HALT_DRAIN) : 1;

   fetch_state_t    state_reg;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] target_aligned;
   logic [CNT_W-1:0] cnt_reg;
   logic            halted_reg;
   logic            ifid_load;
   logic            ifid_flush;

   assign pc_plus4       = pc_reg + XLEN'(4);
   assign target_aligned = branch_target & ~XLEN'(3);
   assign imem_addr      = pc_reg;
   assign halted         = halted_reg;

   always_comb begin
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      case (state_reg)
         RUN: begin
            if (branch_taken)  ifid_flush = 1'b1;
            else if (!stall)   ifid_load  = 1'b1;
         end
         HALT_PEND: begin
            // Younger fetches behind a pending halt are never allowed into decode.
            if (branch_taken || !stall) ifid_flush = 1'b1;
         end
         default: ifid_flush = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= RUN;
         pc_reg     <= XLEN'(RESET_PC);
         cnt_reg    <= '0;
         halted_reg <= 1'b0;
      end else begin
         case (state_reg)
            RUN: begin
               if (branch_taken) begin
                  pc_reg <= target_aligned;
               end else if (!stall) begin
                  if (imem_rdata == HALT_INSTR) begin
                     state_reg <= HALT_PEND;
                     cnt_reg   <= '0;
                  end else begin
                     pc_reg <= pc_plus4;
                  end
               end
            end
            HALT_PEND: begin
               if (branch_taken) begin
                  pc_reg    <= target_aligned;
                  state_reg <= RUN;
               end else if (!stall) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                  if (cnt_reg == CNT_W'(HALT_DRAIN - 1)) begin
                     state_reg  <= HALTED;
                     halted_reg <= 1'b1;
                  end
               end
            end
            HALTED: begin
               halted_reg <= 1'b1;
            end
            default: begin
               state_reg <= RUN;
            end
         endcase
      end
   end

   instruc_fetch_if_id_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) if_id_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (ifid_load),
      .flush       (ifid_flush),
      .pc          (pc_reg),
      .pc_plus4    (pc_plus4),
      .instruc     (imem_rdata),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4),
      .id_instruc  (id_instruc),
      .id_valid    (id_valid)
   );

endmodule
